inst_rom_resp: RTL and testbench

Instruction-memory responder for the fetch port. Each cycle the PC generator drives `ce`/`pc`; this block samples that request, reads a word-addressed instruction store, and returns the instruction plus its address after a fixed pipeline latency. It sits between the PC register and IF/ID. It also provides a loader write port for filling the store, and a flush input that drops wrong-path fetches on redirect.

---
 rtl/inst_rom_resp.sv | 107 ++++++++++
 tb/tb_inst_rom_resp.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_resp.sv
// Instruction-memory responder: samples ce/pc, reads a word store and returns
// {inst, inst_pc, inst_err} after LATENCY cycles. Optional alignment check: IF_RESP_ALIGN_CHECK_EN.
module inst_rom_resp #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           pc,
    input  logic                  flush,
    input  logic                  ld_we,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic [31:0]           inst,
    output logic [31:0]           inst_pc,
    output logic                  inst_valid,
    output logic                  inst_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  out_of_range;
    logic                  misaligned;
    logic                  req_err;
    logic                  req_take;

    assign word_idx     = pc[DEPTH_LOG2+1:2];
    assign out_of_range = |pc[31:DEPTH_LOG2+2];

`ifdef IF_RESP_ALIGN_CHECK_EN
    assign misaligned = |pc[1:0];
`else
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = |pc[1:0];
    assign misaligned     = 1'b0;
`endif

    assign req_err  = out_of_range | misaligned;
    // A request sampled together with flush is dropped outright.
    assign req_take = ce & ~flush;

    // Loader port; non-blocking update gives read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (!rst && ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Payload registers load only when a valid entry arrives, so the final
    // stage naturally holds the last delivered response across bubbles.
    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : gen_stage
            logic        valid_reg;
            logic        err_reg;
            logic [31:0] pc_reg;
            logic [31:0] data_reg;

            if (gi == 0) begin : gen_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        valid_reg <= 1'b0;
                        err_reg   <= 1'b0;
                        pc_reg    <= '0;
                        data_reg  <= '0;
                    end else begin
                        valid_reg <= req_take;
                        if (req_take) begin
                            pc_reg  <= pc;
                            err_reg <= req_err;
                            if (req_err) begin
                                data_reg <= NOP_INST;
                            end else begin
                                data_reg <= mem[word_idx];
                            end
                        end
                    end
                end
            end else begin : gen_tail
                always_ff @(posedge clk) begin
                    if (rst) begin
                        valid_reg <= 1'b0;
                        err_reg   <= 1'b0;
                        pc_reg    <= '0;
                        data_reg  <= '0;
                    end else begin
                        valid_reg <= gen_stage[gi-1].valid_reg & ~flush;
                        if (gen_stage[gi-1].valid_reg && !flush) begin
                            pc_reg   <= gen_stage[gi-1].pc_reg;
                            err_reg  <= gen_stage[gi-1].err_reg;
                            data_reg <= gen_stage[gi-1].data_reg;
                        end
                    end
                end
            end
        end
    endgenerate

    assign inst       = gen_stage[LATENCY-1].data_reg;
    assign inst_pc    = gen_stage[LATENCY-1].pc_reg;
    assign inst_err   = gen_stage[LATENCY-1].err_reg;
    assign inst_valid = gen_stage[LATENCY-1].valid_reg;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Self-checking bench for inst_rom_resp: a latency-1 and a latency-3 instance share
// stimulus and are compared every cycle against a request-history reference model.
module tb_inst_rom_resp;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam int          HIST = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        flush = 1'b0;
    logic        ld_we = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] ld_data = '0;
    logic [9:0]  ld_addr = '0;

    logic [31:0] inst1, pc1, inst3, pc3;
    logic        v1, e1, v3, e3;

    always #5 clk = ~clk;

    inst_rom_resp #(.DEPTH_LOG2(10), .LATENCY(1), .NOP_INST(NOP)) u_dut1 (
        .clk(clk), .rst(rst), .ce(ce), .pc(pc), .flush(flush),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .inst(inst1), .inst_pc(pc1), .inst_valid(v1), .inst_err(e1)
    );

    inst_rom_resp #(.DEPTH_LOG2(10), .LATENCY(3), .NOP_INST(NOP)) u_dut3 (
        .clk(clk), .rst(rst), .ce(ce), .pc(pc), .flush(flush),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .inst(inst3), .inst_pc(pc3), .inst_valid(v3), .inst_err(e3)
    );

    // Packed view {valid, err, pc, inst} per instance.
    logic [65:0] obs [2];
    assign obs[0] = {v1, e1, pc1, inst1};
    assign obs[1] = {v3, e3, pc3, inst3};

    // Reference model: history of what each edge accepted, killed and would return.
    logic [31:0] mem_m [1024];
    bit          acc    [HIST];
    bit          kill   [HIST];
    bit          rst_h  [HIST];
    logic [64:0] resp_h [HIST];
    logic [64:0] hold    [2];
    logic [65:0] exp_vec [2];
    int          cyc    = 0;
    int          n_run  = 0;
    int          n_fail = 0;

    initial begin
        hold[0] = '0;
        hold[1] = '0;
    end

    // Advance one edge and derive the expected outputs for the new cycle:
    // a request sampled at edge t responds in cycle t+L unless a flush or
    // reset occurred on an edge strictly between.
    task automatic tick();
        logic err;
        int   lat;
        bit   v;
        @(posedge clk);
        err = (pc[31:12] != 20'd0);
`ifdef IF_RESP_ALIGN_CHECK_EN
        if (pc[1:0] != 2'd0) err = 1'b1;
`endif
        acc[cyc]    = ce && !flush && !rst;
        kill[cyc]   = flush || rst;
        rst_h[cyc]  = rst;
        resp_h[cyc] = {err, pc, err ? NOP : mem_m[pc[11:2]]};
        if (!rst && ld_we) mem_m[ld_addr] = ld_data;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? 1 : 3;
            v   = 1'b0;
            if (rst_h[cyc-1]) hold[d] = '0;
            if (cyc - lat >= 0 && acc[cyc-lat]) begin
                v = 1'b1;
                for (int e = cyc - lat + 1; e < cyc; e++) if (kill[e]) v = 1'b0;
            end
            if (v) begin
                hold[d] = resp_h[cyc-lat];
                $display("[TB] cyc %0d lat%0d resp pc=%h inst=%h err=%0b",
                         cyc, lat, hold[d][63:32], hold[d][31:0], hold[d][64]);
            end
            exp_vec[d] = {v, hold[d]};
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            rst = (i < 3); ce = 1'b0; flush = 1'b0; ld_we = 1'b0; pc = '0;
            tick();
            for (int d = 0; d < 2; d++) begin
                n_run++;
                if (obs[d] !== exp_vec[d]) begin
                    n_fail++;
                    $display("FAIL reset lat%0d cyc%0d: got %h want %h", d ? 3 : 1, cyc, obs[d], exp_vec[d]);
                end
            end
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < 1024; i++) begin
            ld_we = 1'b1; ld_addr = i[9:0]; ce = 1'b0;
            case (i)
                0: ld_data = 32'h11111111;
                1: ld_data = 32'h22222222;
                2: ld_data = 32'h33333333;
                3: ld_data = 32'h44444444;
                default: ld_data = $urandom;
            endcase
            tick();
            for (int d = 0; d < 2; d++) begin
                n_run++;
                if (obs[d] !== exp_vec[d]) begin
                    n_fail++;
                    $display("FAIL load lat%0d cyc%0d: got %h want %h", d ? 3 : 1, cyc, obs[d], exp_vec[d]);
                end
            end
        end
        ld_we = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 8; i++) begin
            ce = (i < 4); pc = i * 4;
            tick();
            for (int d = 0; d < 2; d++) begin
                n_run++;
                if (obs[d] !== exp_vec[d]) begin
                    n_fail++;
                    $display("FAIL sequential lat%0d cyc%0d: got %h want %h", d ? 3 : 1, cyc, obs[d], exp_vec[d]);
                end
            end
        end
        // Direct check of the last word delivered by the latency-1 instance.
        n_run++;
        if (inst1 !== 32'h44444444 || pc1 !== 32'd12 || e1 !== 1'b0) begin
            n_fail++;
            $display("FAIL sequential_last: got inst=%h pc=%h err=%0b want 44444444 0000000c 0", inst1, pc1, e1);
        end
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 6; i++) begin
            ce = (i < 2); pc = (i == 0) ? 32'h00001000 : 32'hFFFFFFFC;
            tick();
            for (int d = 0; d < 2; d++) begin
                n_run++;
                if (obs[d] !== exp_vec[d]) begin
                    n_fail++;
                    $display("FAIL out_of_range lat%0d cyc%0d: got %h want %h", d ? 3 : 1, cyc, obs[d], exp_vec[d]);
                end
            end
        end
    endtask

    task automatic test_misaligned();
        for (int i = 0; i < 6; i++) begin
            ld_we = (i == 0); ld_addr = 10'd1; ld_data = 32'hAAAA0001;
            ce = (i == 1); pc = 32'h6;
            tick();
            for (int d = 0; d < 2; d++) begin
                n_run++;
                if (obs[d] !== exp_vec[d]) begin
                    n_fail++;
                    $display("FAIL misaligned lat%0d cyc%0d: got %h want %h", d ? 3 : 1, cyc, obs[d], exp_vec[d]);
                end
            end
        end
        ld_we = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 9; i++) begin
            ce = (i < 4); pc = (i < 3) ? i * 4 : 8; flush = (i == 2);
            tick();
            for (int d = 0; d < 2; d++) begin
                n_run++;
                if (obs[d] !== exp_vec[d]) begin
                    n_fail++;
                    $display("FAIL flush lat%0d cyc%0d: got %h want %h", d ? 3 : 1, cyc, obs[d], exp_vec[d]);
                end
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_collision();
        for (int i = 0; i < 7; i++) begin
            ld_we = (i < 2); ld_addr = 10'd5; ld_data = (i == 0) ? 32'hA : 32'hB;
            ce = (i == 1 || i == 2); pc = 32'd20;
            tick();
            for (int d = 0; d < 2; d++) begin
                n_run++;
                if (obs[d] !== exp_vec[d]) begin
                    n_fail++;
                    $display("FAIL collision lat%0d cyc%0d: got %h want %h", d ? 3 : 1, cyc, obs[d], exp_vec[d]);
                end
            end
        end
        ld_we = 1'b0;
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 8; i++) begin
            ce = (i < 2); pc = i * 4; rst = (i == 2);
            tick();
            for (int d = 0; d < 2; d++) begin
                n_run++;
                if (obs[d] !== exp_vec[d]) begin
                    n_fail++;
                    $display("FAIL reset_midflight lat%0d cyc%0d: got %h want %h", d ? 3 : 1, cyc, obs[d], exp_vec[d]);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int kind;
        for (int i = 0; i < 500; i++) begin
            kind  = $urandom_range(0, 9);
            ce    = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 49) == 0);
            ld_we = ($urandom_range(0, 4) == 0);
            ld_addr = $urandom_range(0, 15);
            ld_data = $urandom;
            if (kind < 7)      pc = {20'd0, $urandom_range(0, 15) > 7 ? 10'($urandom) : 10'($urandom_range(0, 15)), 2'b00};
            else if (kind < 9) pc = {20'd0, 10'($urandom_range(0, 15)), 2'($urandom)};
            else               pc = $urandom | 32'h00001000;
            tick();
            for (int d = 0; d < 2; d++) begin
                n_run++;
                if (obs[d] !== exp_vec[d]) begin
                    n_fail++;
                    $display("FAIL random lat%0d cyc%0d: got %h want %h", d ? 3 : 1, cyc, obs[d], exp_vec[d]);
                end
            end
        end
        rst = 1'b0; ce = 1'b0; flush = 1'b0; ld_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_sequential();
        test_out_of_range();
        test_misaligned();
        test_flush();
        test_collision();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
